// File: rtl/mem_block_reader.sv
// mem_block_reader: sequential block read engine.
// Takes a start address and a word count. Reads from a synchronous data
// memory at consecutive addresses (wrapping modulo 2^ADDR_W). Returns the
// words over a valid/ready stream through a 2-entry output buffer.
module mem_block_reader #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  // Credit limit on buffered plus returning words. Only 2 is supported.
  localparam logic [2:0] DEPTH = 3'(BUF_DEPTH);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] issue_left_q;
  logic [ADDR_W-1:0] deliver_left_q;
  logic              busy_q;
  logic              done_q;
  logic              in_flight_q;
  logic [1:0]        occ_q;
  logic [DATA_W-1:0] buf0_q;
  logic [DATA_W-1:0] buf1_q;

  logic              push;
  logic              pop;
  logic [2:0]        occ_d;

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_addr  = addr_q;
  assign out_data  = buf0_q;
  assign out_valid = (occ_q != 2'd0);
  assign out_last  = out_valid && (deliver_left_q == ADDR_W'(1));

  // Buffer handshake and read-issue credit for the current cycle.
  // The strobe is a decode of registered state plus the same-cycle pop.
  // This lets a consumer that is always ready get one word per cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    push      = in_flight_q;
    pop       = out_valid & out_ready;
    occ_d     = {1'b0, occ_q} + {2'b00, push} - {2'b00, pop};
    mem_rd_en = 1'b0;
    if (state_q == READ && issue_left_q != '0 && occ_d < DEPTH) begin
      mem_rd_en = 1'b1;
    end
  end

  // FSM, address/count registers and the 2-entry output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the buffer entries are reset along with control state, so out_data reads 0 after reset.
      state_q        <= IDLE;
      addr_q         <= '0;
      issue_left_q   <= '0;
      deliver_left_q <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      in_flight_q    <= 1'b0;
      occ_q          <= 2'd0;
      buf0_q         <= '0;
      buf1_q         <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; later assignments in this block override earlier ones.
      done_q      <= 1'b0;
      in_flight_q <= mem_rd_en;
      occ_q       <= occ_d[1:0];

      // The head is always buf0. A push fills the first free slot once any pop shift is done.
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) buf0_q <= mem_rdata;
          else               buf1_q <= mem_rdata;
        end
        2'b01: buf0_q <= buf1_q;
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_q <= mem_rdata;
          end else begin
            buf0_q <= buf1_q;
            buf1_q <= mem_rdata;
          end
        end
        default: ;
      endcase

      if (pop) deliver_left_q <= deliver_left_q - ADDR_W'(1);

      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q         <= start_addr;
            issue_left_q   <= count;
            deliver_left_q <= count;
            if (count != '0) begin
              busy_q  <= 1'b1;
              state_q <= READ;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        READ: begin
          if (mem_rd_en) begin
            addr_q       <= addr_q + ADDR_W'(1);
            issue_left_q <= issue_left_q - ADDR_W'(1);
            if (issue_left_q == ADDR_W'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && deliver_left_q == ADDR_W'(1)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
